// File: rtl/coreriscv_axi4_mmio_tl_to_axi4.sv
// Uncached TileLink acquire/grant to AXI4 MMIO master bridge, one transaction in flight.
// Define CORERISCV_AXI4_MMIO_BUS_ERROR_EN to add the sticky bus_error output.
module coreriscv_axi4_mmio_tl_to_axi4 (
  input  logic        clk,
  input  logic        reset,
  output logic        acq_ready,
  input  logic        acq_valid,
  input  logic [25:0] acq_addr_block,
  input  logic [1:0]  acq_client_xact_id,
  input  logic [2:0]  acq_addr_beat,
  input  logic        acq_is_builtin_type,
  input  logic [2:0]  acq_a_type,
  input  logic [11:0] acq_union,
  input  logic [63:0] acq_data,
  input  logic        gnt_ready,
  output logic        gnt_valid,
  output logic [2:0]  gnt_addr_beat,
  output logic [1:0]  gnt_client_xact_id,
  output logic        gnt_manager_xact_id,
  output logic        gnt_is_builtin_type,
  output logic [3:0]  gnt_g_type,
  output logic [63:0] gnt_data,
  output logic        aw_valid,
  input  logic        aw_ready,
  output logic [1:0]  aw_id,
  output logic [31:0] aw_addr,
  output logic [7:0]  aw_len,
  output logic [2:0]  aw_size,
  output logic [1:0]  aw_burst,
  output logic        w_valid,
  input  logic        w_ready,
  output logic [63:0] w_data,
  output logic [7:0]  w_strb,
  output logic        w_last,
  input  logic        b_valid,
  output logic        b_ready,
  input  logic [1:0]  b_id,
  input  logic [1:0]  b_resp,
  output logic        ar_valid,
  input  logic        ar_ready,
  output logic [1:0]  ar_id,
  output logic [31:0] ar_addr,
  output logic [7:0]  ar_len,
  output logic [2:0]  ar_size,
  output logic [1:0]  ar_burst,
  input  logic        r_valid,
  output logic        r_ready,
  input  logic [1:0]  r_id,
  input  logic [63:0] r_data,
  input  logic [1:0]  r_resp,
  input  logic        r_last
`ifdef CORERISCV_AXI4_MMIO_BUS_ERROR_EN
  ,
  output logic        bus_error
`endif
);

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 64;
  localparam int unsigned STRB_W = 8;
  localparam int unsigned ID_W   = 2;
  localparam int unsigned BEAT_W = 3;

  typedef enum logic [2:0] {S_IDLE, S_AR, S_R, S_AW, S_W, S_B, S_NAK} state_t;

  state_t              state_q;
  logic [BEAT_W-1:0]   cnt_q;
  logic [ID_W-1:0]     id_q;
  logic [2:0]          type_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   data_q;
  logic [STRB_W-1:0]   strb_q;
  logic                aw_done_q;
  logic                w_done_q;

  logic is_block, acq_ok;
  logic acq_fire, ar_fire, aw_fire, w_fire, r_fire, b_fire;
  logic aw_seen, w_seen;
  logic [ADDR_W-1:0] axi_addr;

  assign is_block = type_q[0];
  assign acq_ok   = acq_is_builtin_type && (acq_a_type <= 3'd3);
  assign axi_addr = is_block ? {addr_q[ADDR_W-1:6], 6'b000000} : addr_q;

  assign acq_fire = acq_valid & acq_ready;
  assign ar_fire  = ar_valid & ar_ready;
  assign aw_fire  = aw_valid & aw_ready;
  assign w_fire   = w_valid & w_ready;
  assign r_fire   = r_valid & r_ready;
  assign b_fire   = b_valid & b_ready;
  assign aw_seen  = aw_done_q | aw_fire;
  assign w_seen   = w_done_q | w_fire;

  // Channel decode; R and B pass straight through to the grant channel.
  always_comb begin
    acq_ready           = 1'b0;
    gnt_valid           = 1'b0;
    gnt_addr_beat       = '0;
    gnt_client_xact_id  = id_q;
    gnt_manager_xact_id = 1'b0;
    gnt_is_builtin_type = 1'b1;
    gnt_g_type          = 4'd3;
    gnt_data            = '0;
    ar_valid            = 1'b0;
    ar_id               = id_q;
    ar_addr             = axi_addr;
    ar_len              = is_block ? 8'd7 : 8'd0;
    ar_size             = 3'd3;
    ar_burst            = 2'b01;
    aw_valid            = 1'b0;
    aw_id               = id_q;
    aw_addr             = axi_addr;
    aw_len              = is_block ? 8'd7 : 8'd0;
    aw_size             = 3'd3;
    aw_burst            = 2'b01;
    w_valid             = 1'b0;
    w_data              = data_q;
    w_strb              = strb_q;
    w_last              = ~is_block;
    b_ready             = 1'b0;
    r_ready             = 1'b0;
    case (state_q)
      S_IDLE: acq_ready = 1'b1;
      S_AR:   ar_valid  = 1'b1;
      S_R: begin
        gnt_valid     = r_valid;
        r_ready       = gnt_ready;
        gnt_data      = r_data;
        gnt_g_type    = is_block ? 4'd5 : 4'd4;
        gnt_addr_beat = is_block ? cnt_q : addr_q[5:3];
      end
      S_AW: begin
        aw_valid = ~aw_done_q;
        w_valid  = ~w_done_q;
      end
      S_W: begin
        aw_valid  = ~aw_done_q;
        w_valid   = acq_valid & ~w_done_q;
        acq_ready = w_ready & ~w_done_q;
        w_data    = acq_data;
        w_strb    = acq_union[8:1];
        w_last    = (cnt_q == 3'd7);
      end
      S_B: begin
        gnt_valid = b_valid;
        b_ready   = gnt_ready;
      end
      S_NAK: gnt_valid = 1'b1;
      default: ;
    endcase
  end

  // Sequencing, beat counter and request latches.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      id_q      <= '0;
      type_q    <= '0;
      addr_q    <= '0;
      data_q    <= '0;
      strb_q    <= '0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: if (acq_fire) begin
          id_q      <= acq_client_xact_id;
          type_q    <= acq_a_type;
          addr_q    <= {acq_addr_block, acq_addr_beat, 3'b000};
          data_q    <= acq_data;
          strb_q    <= acq_union[8:1];
          cnt_q     <= '0;
          aw_done_q <= 1'b0;
          w_done_q  <= 1'b0;
          if (!acq_ok)            state_q <= S_NAK;
          else if (acq_a_type[1]) state_q <= S_AW;
          else                    state_q <= S_AR;
        end
        S_AR: if (ar_fire) state_q <= S_R;
        S_R: if (r_fire) begin
          cnt_q <= cnt_q + 3'd1;
          if (r_last) state_q <= S_IDLE;
        end
        S_AW: begin
          aw_done_q <= aw_seen;
          w_done_q  <= w_seen;
          if (is_block) begin
            if (w_seen) begin
              state_q  <= S_W;
              cnt_q    <= 3'd1;
              w_done_q <= 1'b0;
            end
          end else if (aw_seen && w_seen) begin
            state_q <= S_B;
          end
        end
        S_W: begin
          if (aw_fire) aw_done_q <= 1'b1;
          if (w_fire) begin
            cnt_q <= cnt_q + 3'd1;
            if (w_last) w_done_q <= 1'b1;
          end
          if (aw_seen && (w_done_q || (w_fire && w_last))) state_q <= S_B;
        end
        S_B:   if (b_fire) state_q <= S_IDLE;
        S_NAK: if (gnt_ready) state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

`ifdef CORERISCV_AXI4_MMIO_BUS_ERROR_EN
  // Sticky error: bad AXI response or unsupported acquire.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bus_error <= 1'b0;
    end else if ((r_fire && r_resp != 2'b00) || (b_fire && b_resp != 2'b00) ||
                 (state_q == S_IDLE && acq_fire && !acq_ok)) begin
      bus_error <= 1'b1;
    end
  end

  logic unused_inputs;
  assign unused_inputs = ^{r_id, b_id, acq_union[11:9], acq_union[0]};
`else
  logic unused_inputs;
  assign unused_inputs = ^{r_id, b_id, r_resp, b_resp, acq_union[11:9], acq_union[0]};
`endif

endmodule

// File: tb/tb_coreriscv_axi4_mmio_tl_to_axi4.sv
// Randomized bench for the TileLink-to-AXI4 MMIO bridge against a transaction-level model.
module tb_coreriscv_axi4_mmio_tl_to_axi4;

  logic        clk = 1'b0;
  logic        reset;
  logic        acq_ready, acq_valid;
  logic [25:0] acq_addr_block;
  logic [1:0]  acq_client_xact_id;
  logic [2:0]  acq_addr_beat;
  logic        acq_is_builtin_type;
  logic [2:0]  acq_a_type;
  logic [11:0] acq_union;
  logic [63:0] acq_data;
  logic        gnt_ready, gnt_valid;
  logic [2:0]  gnt_addr_beat;
  logic [1:0]  gnt_client_xact_id;
  logic        gnt_manager_xact_id, gnt_is_builtin_type;
  logic [3:0]  gnt_g_type;
  logic [63:0] gnt_data;
  logic        aw_valid, aw_ready;
  logic [1:0]  aw_id;
  logic [31:0] aw_addr;
  logic [7:0]  aw_len;
  logic [2:0]  aw_size;
  logic [1:0]  aw_burst;
  logic        w_valid, w_ready;
  logic [63:0] w_data;
  logic [7:0]  w_strb;
  logic        w_last;
  logic        b_valid, b_ready;
  logic [1:0]  b_id, b_resp;
  logic        ar_valid, ar_ready;
  logic [1:0]  ar_id;
  logic [31:0] ar_addr;
  logic [7:0]  ar_len;
  logic [2:0]  ar_size;
  logic [1:0]  ar_burst;
  logic        r_valid, r_ready;
  logic [1:0]  r_id;
  logic [63:0] r_data;
  logic [1:0]  r_resp;
  logic        r_last;
`ifdef CORERISCV_AXI4_MMIO_BUS_ERROR_EN
  logic        bus_error;
`endif

  coreriscv_axi4_mmio_tl_to_axi4 dut (
    .clk(clk), .reset(reset),
    .acq_ready(acq_ready), .acq_valid(acq_valid), .acq_addr_block(acq_addr_block),
    .acq_client_xact_id(acq_client_xact_id), .acq_addr_beat(acq_addr_beat),
    .acq_is_builtin_type(acq_is_builtin_type), .acq_a_type(acq_a_type),
    .acq_union(acq_union), .acq_data(acq_data),
    .gnt_ready(gnt_ready), .gnt_valid(gnt_valid), .gnt_addr_beat(gnt_addr_beat),
    .gnt_client_xact_id(gnt_client_xact_id), .gnt_manager_xact_id(gnt_manager_xact_id),
    .gnt_is_builtin_type(gnt_is_builtin_type), .gnt_g_type(gnt_g_type), .gnt_data(gnt_data),
    .aw_valid(aw_valid), .aw_ready(aw_ready), .aw_id(aw_id), .aw_addr(aw_addr),
    .aw_len(aw_len), .aw_size(aw_size), .aw_burst(aw_burst),
    .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data), .w_strb(w_strb), .w_last(w_last),
    .b_valid(b_valid), .b_ready(b_ready), .b_id(b_id), .b_resp(b_resp),
    .ar_valid(ar_valid), .ar_ready(ar_ready), .ar_id(ar_id), .ar_addr(ar_addr),
    .ar_len(ar_len), .ar_size(ar_size), .ar_burst(ar_burst),
    .r_valid(r_valid), .r_ready(r_ready), .r_id(r_id), .r_data(r_data),
    .r_resp(r_resp), .r_last(r_last)
`ifdef CORERISCV_AXI4_MMIO_BUS_ERROR_EN
    , .bus_error(bus_error)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  logic [63:0] wdat [8];
  logic [7:0]  wstrb[8];
  logic [63:0] rdat [8];
  bit stall_ar, late_aw, gnt_stall;
  bit err_exp;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic idle_inputs();
    acq_valid = 1'b0; acq_addr_block = '0; acq_client_xact_id = '0; acq_addr_beat = '0;
    acq_is_builtin_type = 1'b1; acq_a_type = '0; acq_union = '0; acq_data = '0;
    gnt_ready = 1'b0; aw_ready = 1'b0; w_ready = 1'b0; b_valid = 1'b0; b_id = '0;
    b_resp = '0; ar_ready = 1'b0; r_valid = 1'b0; r_id = '0; r_data = '0; r_resp = '0;
    r_last = 1'b0;
  endtask

  task automatic fill_random();
    for (int i = 0; i < 8; i++) begin
      wdat[i]  = {$urandom, $urandom};
      wstrb[i] = 8'($urandom);
      rdat[i]  = {$urandom, $urandom};
    end
  endtask

  // One TileLink transaction with the bench acting as a randomly stalling AXI slave.
  task automatic run_txn(input logic bi, input logic [2:0] at, input logic [25:0] blk,
                         input logic [2:0] bt, input logic [1:0] id, input logic [1:0] rsp,
                         input int abort_w);
    bit is_rd, is_wr, blkm, fired0, ar_seen, aw_seen, exp_wv, exp_gv;
    int nacq, nr, nw, ngnt, acq_sent, w_cnt, r_sent, gnt_cnt, cyc, ar_wait, r_stall, idx;
    logic [31:0] exp_addr;
    is_rd = bi && (at <= 3'd1);
    is_wr = bi && (at == 3'd2 || at == 3'd3);
    blkm  = at[0];
    nr = blkm ? 8 : 1;
    nw = blkm ? 8 : 1;
    nacq = (is_wr && blkm) ? 8 : 1;
    ngnt = is_rd ? nr : 1;
    exp_addr = {blk, bt, 3'b000};
    if (blkm) exp_addr[5:3] = 3'b000;
    acq_sent = 0; w_cnt = 0; r_sent = 0; gnt_cnt = 0; cyc = 0; ar_wait = 0; r_stall = 0;
    ar_seen = 0; aw_seen = 0;
    while (gnt_cnt < ngnt && cyc < 500) begin
      @(negedge clk);
      cyc++;
      idx = (acq_sent < 8) ? acq_sent : 7;
      acq_valid = (acq_sent < nacq) && (acq_sent == 0 || $urandom_range(3) != 0);
      acq_is_builtin_type = bi; acq_a_type = at; acq_addr_block = blk;
      acq_addr_beat = bt; acq_client_xact_id = id;
      acq_data = wdat[idx];
      acq_union = {3'b000, wstrb[idx], 1'b0};
      ar_ready = stall_ar ? (ar_wait >= 4) : ($urandom_range(2) != 0);
      aw_ready = late_aw ? (w_cnt == nw) : ($urandom_range(2) != 0);
      w_ready  = $urandom_range(3) != 0;
      idx = (r_sent < 8) ? r_sent : 7;
      r_valid = ar_seen && (r_sent < nr) && ($urandom_range(3) != 0);
      r_data = rdat[idx]; r_last = (r_sent == nr - 1); r_resp = rsp; r_id = id;
      b_valid = aw_seen && (w_cnt == nw) && ($urandom_range(2) != 0);
      b_resp = rsp; b_id = id;
      if (gnt_stall && is_rd && r_sent == 3 && r_stall < 3) begin
        gnt_ready = 1'b0;
        r_stall++;
      end else begin
        gnt_ready = $urandom_range(3) != 0;
      end
      if (abort_w >= 0 && is_wr && w_cnt == abort_w) begin
        #2 reset = 1'b0;
        #1;
        chk("rst_ar_valid", ar_valid, 0);
        chk("rst_aw_valid", aw_valid, 0);
        chk("rst_w_valid", w_valid, 0);
        chk("rst_gnt_valid", gnt_valid, 0);
        chk("rst_acq_ready", acq_ready, 1);
        idle_inputs();
        repeat (2) @(negedge clk);
        reset = 1'b1;
        err_exp = 1'b0;
        return;
      end
      #1;
      fired0 = (acq_sent > 0);
      chk("ar_valid", ar_valid, is_rd && fired0 && !ar_seen);
      chk("aw_valid", aw_valid, is_wr && fired0 && !aw_seen);
      exp_wv = is_wr && fired0 && ((w_cnt == 0) ? 1'b1 : ((w_cnt < nw) ? acq_valid : 1'b0));
      chk("w_valid", w_valid, exp_wv);
      if (!fired0)    exp_gv = 1'b0;
      else if (is_rd) exp_gv = ar_seen ? r_valid : 1'b0;
      else if (is_wr) exp_gv = (aw_seen && w_cnt == nw) ? b_valid : 1'b0;
      else            exp_gv = 1'b1;
      chk("gnt_valid", gnt_valid, exp_gv);
      if (is_rd && ar_seen) chk("r_ready", r_ready, gnt_ready);
      if (is_wr && aw_seen && w_cnt == nw) chk("b_ready", b_ready, gnt_ready);
      if (!fired0) chk("acq_ready_idle", acq_ready, 1);
      else if (is_wr && blkm && w_cnt >= 1 && w_cnt < 8) chk("acq_ready_w", acq_ready, w_ready);
      else if (!(is_wr && blkm && w_cnt == 8)) chk("acq_ready_busy", acq_ready, 0);
      if (ar_valid) begin
        chk("ar_addr", ar_addr, exp_addr);
        if (ar_ready) begin
          chk("ar_len", ar_len, blkm ? 7 : 0);
          chk("ar_id", ar_id, id);
          chk("ar_size", ar_size, 3);
          chk("ar_burst", ar_burst, 1);
          ar_seen = 1;
        end else begin
          ar_wait++;
        end
      end
      if (aw_valid) begin
        chk("aw_addr", aw_addr, exp_addr);
        if (aw_ready) begin
          chk("aw_len", aw_len, blkm ? 7 : 0);
          chk("aw_id", aw_id, id);
          chk("aw_size", aw_size, 3);
          chk("aw_burst", aw_burst, 1);
          aw_seen = 1;
        end
      end
      if (w_valid && w_ready) begin
        idx = (w_cnt < 8) ? w_cnt : 7;
        chk("w_data", w_data, wdat[idx]);
        chk("w_strb", w_strb, wstrb[idx]);
        chk("w_last", w_last, w_cnt == nw - 1);
        w_cnt++;
      end
      if (gnt_valid && gnt_ready) begin
        idx = (r_sent < 8) ? r_sent : 7;
        chk("gnt_client_id", gnt_client_xact_id, id);
        chk("gnt_mgr_id", gnt_manager_xact_id, 0);
        chk("gnt_builtin", gnt_is_builtin_type, 1);
        chk("gnt_g_type", gnt_g_type, is_rd ? (blkm ? 5 : 4) : 3);
        chk("gnt_addr_beat", gnt_addr_beat, is_rd ? (blkm ? 3'(r_sent) : bt) : 3'd0);
        chk("gnt_data", gnt_data, is_rd ? rdat[idx] : 64'd0);
        if ((is_rd || is_wr) && rsp != 2'b00) err_exp = 1'b1;
        if (is_rd) r_sent++;
        gnt_cnt++;
      end
      if (acq_valid && acq_ready) begin
        if (acq_sent == 0 && !(is_rd || is_wr)) err_exp = 1'b1;
        acq_sent++;
      end
    end
    chk("txn_grants", gnt_cnt, ngnt);
    if (is_wr) chk("txn_w_beats", w_cnt, nw);
    @(negedge clk);
    idle_inputs();
    #1;
    chk("back_idle", {acq_ready, ar_valid, aw_valid, w_valid, gnt_valid}, 5'b10000);
`ifdef CORERISCV_AXI4_MMIO_BUS_ERROR_EN
    chk("bus_error", bus_error, err_exp);
`endif
  endtask

  initial begin
    logic [2:0] at;
    logic bi;
    int kind;
    stall_ar = 0; late_aw = 0; gnt_stall = 0; err_exp = 0;
    idle_inputs();
    reset = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("reset_acq_ready", acq_ready, 1);
    chk("reset_valids", {ar_valid, aw_valid, w_valid, gnt_valid, r_ready, b_ready}, 6'b0);
`ifdef CORERISCV_AXI4_MMIO_BUS_ERROR_EN
    chk("reset_bus_error", bus_error, 0);
`endif
    @(negedge clk);
    reset = 1'b1;

    fill_random();
    rdat[0] = 64'h0000_0000_DEAD_BEEF;
    run_txn(1'b1, 3'd0, 26'h0000010, 3'd5, 2'd2, 2'd0, -1);

    fill_random();
    stall_ar = 1; gnt_stall = 1;
    run_txn(1'b1, 3'd1, 26'($urandom), 3'd6, 2'd1, 2'd0, -1);
    stall_ar = 0; gnt_stall = 0;

    fill_random();
    wdat[0] = 64'h1122_3344_5566_7788; wstrb[0] = 8'h0F;
    run_txn(1'b1, 3'd2, 26'($urandom), 3'd3, 2'd3, 2'd0, -1);

    fill_random();
    late_aw = 1;
    run_txn(1'b1, 3'd3, 26'($urandom), 3'd2, 2'd0, 2'd0, -1);
    late_aw = 0;

    run_txn(1'b1, 3'd4, 26'($urandom), 3'd1, 2'd1, 2'd0, -1);
    fill_random();
    run_txn(1'b1, 3'd2, 26'($urandom), 3'd0, 2'd2, 2'd2, -1);

    fill_random();
    run_txn(1'b1, 3'd3, 26'($urandom), 3'd4, 2'd3, 2'd0, 3);
    fill_random();
    run_txn(1'b1, 3'd0, 26'($urandom), 3'd7, 2'd1, 2'd0, -1);

    for (int t = 0; t < 40; t++) begin
      fill_random();
      kind = $urandom_range(9);
      bi = 1'b1;
      if (kind < 8)       at = 3'(kind / 2);
      else if (kind == 8) at = 3'(4 + $urandom_range(3));
      else begin
        bi = 1'b0;
        at = 3'($urandom_range(7));
      end
      stall_ar = ($urandom_range(3) == 0);
      late_aw  = ($urandom_range(3) == 0);
      run_txn(bi, at, 26'($urandom), 3'($urandom), 2'($urandom),
              ($urandom_range(7) == 0) ? 2'd2 : 2'd0, -1);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
